// File: rtl/f11_svc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : f11_svc_if                                                 |
// | Description : Board-side request/status bundle of the F-11 service word  |
// |               generator; slave = generator, master = board/control side. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface f11_svc_if;
   logic        pin_mce_p;
   logic        pin_mce_n;
   logic [3:0]  pin_irq;
   logic        pin_evnt;
   logic        pin_evnt_ack;
   logic        pin_aclo;
   logic        pin_dclo;
   logic        pin_halt;
   logic        pin_ccerr;
   logic        pin_mmu_abt;
   logic        pin_parerr;
   logic        pin_bsy;
   logic        pin_rply;
   logic        pin_err_clr;
   logic [12:0] pin_svc;

   modport slave (
      input  pin_mce_p, pin_mce_n, pin_irq, pin_evnt, pin_evnt_ack,
             pin_aclo, pin_dclo, pin_halt, pin_ccerr, pin_mmu_abt,
             pin_parerr, pin_bsy, pin_rply, pin_err_clr,
      output pin_svc
   );

   modport master (
      output pin_mce_p, pin_mce_n, pin_irq, pin_evnt, pin_evnt_ack,
             pin_aclo, pin_dclo, pin_halt, pin_ccerr, pin_mmu_abt,
             pin_parerr, pin_bsy, pin_rply, pin_err_clr,
      input  pin_svc
   );
endinterface
`default_nettype wire

// File: rtl/f11_svc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : f11_svc                                                    |
// | Description : F-11 service word generator: synchronizes board requests,  |
// |               latches sticky errors/events, registers word on mce_n.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module f11_svc #(
   parameter int TOUT_CYCLES = 64
) (
   input  wire logic  pin_clk,
   input  wire logic  pin_rst,
   f11_svc_if.slave   bus
);

   localparam int             CW         = $clog2(TOUT_CYCLES) + 1;
   localparam logic [CW-1:0]  C_TOUT_MAX = CW'(TOUT_CYCLES - 1);
   localparam logic [12:0]    C_SVR_RST  = 13'h001C;

   logic [3:0]    irq_s1_q, irq_s2_q;
   logic          evnt_s1_q, evnt_s2_q, evnt_h_q;
   logic          aclo_s1_q, aclo_s2_q;
   logic          dclo_s1_q, dclo_s2_q;
   logic          halt_s1_q, halt_s2_q;
   logic          rply_s1_q, rply_s2_q;

   logic          evt_q, evt_d;
   logic          tout_q, tout_d;
   logic          par_q, par_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [12:0]   svr_q, svr_d;

   logic          w_evt_edge;
   logic          w_counting;
   logic          w_tout_set;
   logic          w_unused;

   always_ff @(posedge pin_clk or posedge pin_rst) begin
      if (pin_rst) begin
         irq_s1_q  <= 4'b0000;
         irq_s2_q  <= 4'b0000;
         evnt_s1_q <= 1'b0;
         evnt_s2_q <= 1'b0;
         evnt_h_q  <= 1'b0;
         aclo_s1_q <= 1'b1;
         aclo_s2_q <= 1'b1;
         dclo_s1_q <= 1'b1;
         dclo_s2_q <= 1'b1;
         halt_s1_q <= 1'b0;
         halt_s2_q <= 1'b0;
         rply_s1_q <= 1'b0;
         rply_s2_q <= 1'b0;
      end else begin
         irq_s1_q  <= bus.pin_irq;
         irq_s2_q  <= irq_s1_q;
         evnt_s1_q <= bus.pin_evnt;
         evnt_s2_q <= evnt_s1_q;
         evnt_h_q  <= evnt_s2_q;
         aclo_s1_q <= bus.pin_aclo;
         aclo_s2_q <= aclo_s1_q;
         dclo_s1_q <= bus.pin_dclo;
         dclo_s2_q <= dclo_s1_q;
         halt_s1_q <= bus.pin_halt;
         halt_s2_q <= halt_s1_q;
         rply_s1_q <= bus.pin_rply;
         rply_s2_q <= rply_s1_q;
      end
   end

   assign w_evt_edge = evnt_s2_q & ~evnt_h_q;
   assign w_counting = bus.pin_bsy & ~rply_s2_q;
   assign w_tout_set = w_counting & (cnt_q == C_TOUT_MAX);
   assign w_unused   = bus.pin_mce_p;

   // Sticky latches: a set on the same clock as a clear always wins.
   always_comb begin
      evt_d  = w_evt_edge | (evt_q & ~(bus.pin_evnt_ack & bus.pin_mce_n));
      tout_d = w_tout_set | (tout_q & ~(bus.pin_err_clr & bus.pin_mce_n));
      par_d  = bus.pin_parerr | (par_q & ~(bus.pin_err_clr & bus.pin_mce_n));

      cnt_d = cnt_q;
      if (!w_counting) begin
         cnt_d = '0;
      end else if (cnt_q != C_TOUT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      svr_d = svr_q;
      if (bus.pin_mce_n) begin
         svr_d = {evt_q, irq_s2_q[0], irq_s2_q[1], irq_s2_q[2], irq_s2_q[3],
                  ~aclo_s2_q, 1'b0, halt_s2_q, ~bus.pin_ccerr,
                  ~bus.pin_mmu_abt, ~par_q, tout_q, ~dclo_s2_q};
      end
   end

   always_ff @(posedge pin_clk or posedge pin_rst) begin
      if (pin_rst) begin
         evt_q  <= 1'b0;
         tout_q <= 1'b0;
         par_q  <= 1'b0;
         cnt_q  <= '0;
         svr_q  <= C_SVR_RST;
      end else begin
         evt_q  <= evt_d;
         tout_q <= tout_d;
         par_q  <= par_d;
         cnt_q  <= cnt_d;
         svr_q  <= svr_d;
      end
   end

   assign bus.pin_svc = svr_q;

endmodule
`default_nettype wire

// File: tb/tb_f11_svc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_f11_svc                                                 |
// | Description : Directed self-checking bench for f11_svc (TOUT_CYCLES=8).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_f11_svc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_n   = 0;
   bit   auto_mce = 1'b0;

   f11_svc_if bus ();

   f11_svc #(.TOUT_CYCLES(8)) dut (
      .pin_clk (clk),
      .pin_rst (rst),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (auto_mce) begin
         bus.pin_mce_n = (cyc_n % 4 == 0);
         bus.pin_mce_p = (cyc_n % 4 == 2);
      end
   endtask

   task automatic cycs(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_n();
      bus.pin_mce_n = 1'b1;
      cyc();
      bus.pin_mce_n = 1'b0;
   endtask

   logic [12:0] prev;
   logic        m;

   initial begin
      bus.pin_mce_p = 0; bus.pin_mce_n = 0; bus.pin_irq = 4'b0000;
      bus.pin_evnt = 0; bus.pin_evnt_ack = 0; bus.pin_aclo = 1; bus.pin_dclo = 1;
      bus.pin_halt = 0; bus.pin_ccerr = 0; bus.pin_mmu_abt = 0; bus.pin_parerr = 0;
      bus.pin_bsy = 0; bus.pin_rply = 0; bus.pin_err_clr = 0;

      // Reset, including mce_n and parity/event activity while held
      bus.pin_parerr = 1; bus.pin_evnt = 1; bus.pin_mce_n = 1;
      cycs(3);
      chk("reset_held", bus.pin_svc, 13'h001C);
      bus.pin_parerr = 0; bus.pin_evnt = 0; bus.pin_mce_n = 0;
      cycs(2);
      rst = 1'b0;
      cycs(3);
      pulse_n();
      chk("reset_released", bus.pin_svc, 13'h001C);

      // Power good
      bus.pin_dclo = 0; bus.pin_aclo = 0;
      cycs(2);
      pulse_n();
      chk("power_ok", bus.pin_svc, 13'h009D);

      // IRQ6 with free-running mce_n every 4 clocks
      auto_mce = 1'b1;
      bus.pin_irq = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         prev = bus.pin_svc;
         m    = bus.pin_mce_n;
         cyc();
         if (!m) chk("hold_no_mce", bus.pin_svc, prev);
      end
      chk("irq6_bit", {12'b0, bus.pin_svc[9]}, 13'd1);
      auto_mce = 1'b0;
      bus.pin_mce_n = 0; bus.pin_mce_p = 0;
      cycs(2);
      chk("irq6_word", bus.pin_svc, 13'h029D);

      // Event pulse sets and holds evt
      bus.pin_evnt = 1; cyc();
      bus.pin_evnt = 0; cycs(3);
      pulse_n();
      chk("evt_set", {12'b0, bus.pin_svc[12]}, 13'd1);
      cycs(3);
      pulse_n();
      chk("evt_held", bus.pin_svc, 13'h129D);
      bus.pin_evnt_ack = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_evnt_ack = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("evt_ack", {12'b0, bus.pin_svc[12]}, 13'd0);

      // Ack on the same clock as a new edge: set wins
      bus.pin_evnt = 1; cyc();
      bus.pin_evnt = 0; cyc();
      bus.pin_evnt_ack = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_evnt_ack = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("evt_ack_vs_edge", {12'b0, bus.pin_svc[12]}, 13'd1);
      bus.pin_evnt_ack = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_evnt_ack = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("evt_ack2", bus.pin_svc, 13'h029D);

      // Timeout boundary: 7 busy clocks is not enough, 8 is
      bus.pin_bsy = 1; cycs(7); bus.pin_bsy = 0;
      pulse_n();
      chk("tout_7clk", {12'b0, bus.pin_svc[1]}, 13'd0);
      bus.pin_bsy = 1; cycs(8); bus.pin_bsy = 0;
      pulse_n();
      chk("tout_8clk", {12'b0, bus.pin_svc[1]}, 13'd1);
      bus.pin_err_clr = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_err_clr = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("tout_clr", bus.pin_svc, 13'h029D);

      // Reply at clock 3 prevents the timeout
      bus.pin_bsy = 1; cycs(3);
      bus.pin_rply = 1; cycs(7);
      bus.pin_bsy = 0; bus.pin_rply = 0;
      cycs(2);
      pulse_n();
      chk("tout_rply", {12'b0, bus.pin_svc[1]}, 13'd0);

      // Reset mid-count restarts the counter
      bus.pin_bsy = 1; cycs(5);
      rst = 1'b1; cyc();
      chk("reset_mid", bus.pin_svc, 13'h001C);
      rst = 1'b0;
      cycs(7); bus.pin_bsy = 0;
      pulse_n();
      chk("count_restart", bus.pin_svc, 13'h029D);

      // Parity latch together with a set timeout, then error clear
      bus.pin_bsy = 1; cycs(9); bus.pin_bsy = 0;
      bus.pin_parerr = 1; cyc(); bus.pin_parerr = 0;
      pulse_n();
      chk("par_tout_set", bus.pin_svc[2:1], 2'b01);
      bus.pin_err_clr = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_err_clr = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("par_tout_clr", bus.pin_svc[2:1], 2'b10);

      // Clear on the same clock as a parity strobe: set wins
      bus.pin_parerr = 1; bus.pin_err_clr = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_parerr = 0; bus.pin_err_clr = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("par_clr_vs_set", {12'b0, bus.pin_svc[2]}, 13'd0);
      bus.pin_err_clr = 1; bus.pin_mce_n = 1; cyc();
      bus.pin_err_clr = 0; bus.pin_mce_n = 0;
      pulse_n();
      chk("par_clr2", bus.pin_svc, 13'h029D);

      // Remaining bit positions: halt, ccerr, mmu abort, irq7
      bus.pin_halt = 1; bus.pin_ccerr = 1; bus.pin_mmu_abt = 1; bus.pin_irq = 4'b1100;
      cycs(2);
      pulse_n();
      chk("misc_bits", bus.pin_svc, 13'h03A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
